// File: rtl/p2s_share_arbiter.sv
// Round-robin owner of the shared P2S shifter: port 0 = 7-seg image, port 1 = LED image; start strobe 1 cycle after grant.
// Ack 1 cycle after shifter EN returns high (earliest 4 cycles after req); requesters hold req level until ack, aborts pulse err.
module p2s_share_arbiter #(
  parameter int unsigned                DATA_BITS    = 64,
  parameter int unsigned                START_WAIT   = 4,
  parameter int unsigned                TIMEOUT_BITS = 16,
  parameter logic [TIMEOUT_BITS-1:0]    TIMEOUT      = 16'd4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 p2s_start,
  output logic [DATA_BITS-1:0] p2s_data,
  input  logic                 p2s_en,
  output logic                 busy,
  output logic                 owner,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    ACK
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] START_LAST = TIMEOUT_BITS'(START_WAIT - 1);
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST    = TIMEOUT - 1'b1;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   p2s_data_q, p2s_data_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic                   p2s_start_q, p2s_start_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   owner_q, owner_d;
  logic                   grant_vld;
  logic                   grant_idx;

  // Contention goes to whoever did not win last time.
  always_comb begin
    grant_vld = req0 | req1;
    if (req0 && req1) grant_idx = ~owner_q;
    else              grant_idx = req1;
  end

  always_comb begin
    state_d     = state_q;
    p2s_data_d  = p2s_data_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    p2s_start_d = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d     = grant_idx;
          p2s_data_d  = grant_idx ? data1 : data0;
          p2s_start_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!p2s_en) begin
          wd_d    = '0;
          state_d = WAIT_DONE;
        end else if (wd_q >= START_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (p2s_en) begin
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = ACK;
        end else if (wd_q >= WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p2s_data_q  <= '0;
      wd_q        <= '0;
      p2s_start_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      p2s_data_q  <= p2s_data_d;
      wd_q        <= wd_d;
      p2s_start_q <= p2s_start_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign p2s_start = p2s_start_q;
  assign p2s_data  = p2s_data_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: doc/p2s_share_arbiter.md
Name: p2s_share_arbiter

Overview:
- Sequences and shares the single parallel-to-serial shifter (P2S) that drives the board's serial display chain.
- Serves two requesters: port 0 (7-segment image) and port 1 (LED image).
- Each accepted request latches that requester's word, pulses the shifter's start input, and waits for shifting to finish. The requester then gets a one-cycle acknowledge.
- Arbitration between requesters is round-robin. A watchdog aborts a transfer whose shifter never completes.

Parameters:
- DATA_BITS, 64, width of each requester word and of the shifter parallel input.
- START_WAIT, 4, maximum cycles to wait for shifter p2s_en to fall after the start pulse.
- TIMEOUT_BITS, 16, width of the shift-completion watchdog counter.
- TIMEOUT, 16'd4000, maximum cycles p2s_en may stay low before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  requester 0 wants a transfer (level).
- data0  in  DATA_BITS  requester 0 word.
- ack0  out  1  one-cycle pulse: requester 0 transfer finished.
- req1  in  1  requester 1 wants a transfer (level).
- data1  in  DATA_BITS  requester 1 word.
- ack1  out  1  one-cycle pulse: requester 1 transfer finished.
- p2s_start  out  1  one-cycle start strobe to the shifter Serial input.
- p2s_data  out  DATA_BITS  word to the shifter P_Data input.
- p2s_en  in  1  shifter EN: 1 = idle/complete, 0 = shifting.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or last granted requester.
- err  out  1  one-cycle pulse on abort (start not seen or timeout).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, p2s_start=0, p2s_data=0, ack0=ack1=0, err=0, busy=0, owner=1, watchdog=0. With owner=1 after reset, requester 0 wins the first contention.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE, ACK.
- IDLE:
  - Sample req0/req1.
  - If exactly one is high, grant it.
  - If both are high, grant the index != owner (round-robin).
  - On grant: owner<=index, p2s_data<=selected data, p2s_start<=1, next state LOAD.
  - With no request, stay in IDLE; p2s_data holds its last value.
- LOAD: p2s_start is high for exactly this one cycle, then 0. Clear the watchdog. Next state WAIT_START.
- WAIT_START:
  - If p2s_en==0, go to WAIT_DONE.
  - Otherwise count. If START_WAIT cycles pass with p2s_en still 1, pulse err and return to IDLE with no ack.
- WAIT_DONE:
  - Increment the watchdog each cycle.
  - When p2s_en==1, go to ACK.
  - If the watchdog reaches TIMEOUT-1 with p2s_en still 0, pulse err and go to IDLE with no ack.
  - The watchdog saturates and never wraps.
- ACK: pulse ack[owner] for one cycle, then IDLE.
- Data stability: p2s_data is stable from LOAD through ACK. Changes on data0/data1 after the grant are ignored.
- Request/ack rules:
  - Requesters must deassert req on the cycle ack is seen.
  - A req still high in the IDLE cycle after ACK is treated as a new request, subject to round-robin.
- Latency: req in IDLE at cycle t → p2s_start high at t+1 → ack at the earliest t+4 (p2s_en low at t+2, high at t+3).
- Request timing:
  - A req raised during a transfer waits until IDLE.
  - A req dropped before IDLE samples it is never served.
- Reset mid-transfer: abort immediately to the reset values, with no ack and no err. The shifter is not signalled.
- Simultaneous cases:
  - err and ack never fire in the same cycle.
  - At most one ack per cycle.
  - p2s_start never asserts outside LOAD.

Test Plan:
1. Reset, then req0=1 with data0=64'hDEAD_BEEF_0123_4567; shifter model drops p2s_en 1 cycle after start and raises it 20 cycles later → p2s_start single pulse at t+1, p2s_data=DEAD_BEEF_0123_4567, one ack0 pulse, owner=0, busy low after ack.
2. req0 and req1 both held high continuously; each requester drops req on its ack, then re-raises it 2 cycles later → grant order 0,1,0,1, ack0/ack1 alternate, never two consecutive acks to the same index.
3. Shifter model never lowers p2s_en after start → err pulse at LOAD+START_WAIT+1 cycles, no ack, returns to IDLE; the next req1 is served normally.
4. TIMEOUT=16 override; p2s_en held low forever → err exactly 16 cycles into WAIT_DONE, no ack, watchdog does not wrap.
5. data0 changed to 64'h0 during WAIT_DONE → p2s_data unchanged until the next grant.
6. rst asserted during WAIT_DONE → next cycle shows all reset values, no ack, no err; after rst falls, req1 alone is granted.
